// File: rtl/axi3_wr_arbiter_if.sv
// Requester-side write channels and the shared AXI3 write master channels
// of the write arbiter; "master" is the arbiter's view, "slave" the environment's.
interface axi3_wr_arbiter_if #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned BUS_WIDTH = 4
);
  logic [N_REQ*32-1:0]  req_awaddr;
  logic [N_REQ*4-1:0]   req_awlen;
  logic [N_REQ*3-1:0]   req_awsize;
  logic [N_REQ-1:0]     req_awvalid;
  logic [N_REQ-1:0]     req_awready;
  logic [N_REQ*32-1:0]  req_wdata;
  logic [N_REQ*4-1:0]   req_wstrb;
  logic [N_REQ-1:0]     req_wlast;
  logic [N_REQ-1:0]     req_wvalid;
  logic [N_REQ-1:0]     req_wready;
  logic [N_REQ-1:0]     req_bvalid;
  logic [N_REQ-1:0]     req_bready;
  logic [1:0]           req_bresp;

  logic [BUS_WIDTH-1:0] m_awid;
  logic [31:0]          m_awaddr;
  logic [3:0]           m_awlen;
  logic [2:0]           m_awsize;
  logic [1:0]           m_awburst;
  logic                 m_awvalid;
  logic                 m_awready;
  logic [BUS_WIDTH-1:0] m_wid;
  logic [31:0]          m_wdata;
  logic [3:0]           m_wstrb;
  logic                 m_wlast;
  logic                 m_wvalid;
  logic                 m_wready;
  logic [BUS_WIDTH-1:0] m_bid;
  logic [1:0]           m_bresp;
  logic                 m_bvalid;
  logic                 m_bready;

  logic [N_REQ-1:0]     grant;
  logic                 protocol_err;

  modport master (
    input  req_awaddr, req_awlen, req_awsize, req_awvalid,
    input  req_wdata, req_wstrb, req_wlast, req_wvalid, req_bready,
    output req_awready, req_wready, req_bvalid, req_bresp,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    output grant, protocol_err
  );

  modport slave (
    output req_awaddr, req_awlen, req_awsize, req_awvalid,
    output req_wdata, req_wstrb, req_wlast, req_wvalid, req_bready,
    input  req_awready, req_wready, req_bvalid, req_bresp,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    input  grant, protocol_err
  );
endinterface

// File: rtl/axi3_wr_arbiter.sv
// Round-robin arbiter sharing one AXI3 write master among N_REQ requesters,
// one transaction outstanding at a time, with locally generated WLAST.
module axi3_wr_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned AWID      = 2,
  parameter int unsigned BUS_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi3_wr_arbiter_if.master  bus
);
  localparam int unsigned GW = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   g;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   sel;
  logic [GW-1:0]   cand;
  logic            sel_vld;
  logic [3:0]      beat_cnt;
  logic [3:0]      len_q;
  logic            last_beat;
  logic            w_hs;
  logic            b_hs;

  logic [31:0]     awaddr_a [N_REQ];
  logic [3:0]      awlen_a  [N_REQ];
  logic [2:0]      awsize_a [N_REQ];
  logic [31:0]     wdata_a  [N_REQ];
  logic [3:0]      wstrb_a  [N_REQ];

  // Unpacked per-requester views of the flat payload buses
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      awaddr_a[i] = bus.req_awaddr[i*32 +: 32];
      awlen_a[i]  = bus.req_awlen[i*4 +: 4];
      awsize_a[i] = bus.req_awsize[i*3 +: 3];
      wdata_a[i]  = bus.req_wdata[i*32 +: 32];
      wstrb_a[i]  = bus.req_wstrb[i*4 +: 4];
    end
  end

  // Descending scan so the requester closest after last_grant wins
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = GW'((32'(last_grant) + 32'(i)) % N_REQ);
      if (bus.req_awvalid[cand]) begin
        sel     = cand;
        sel_vld = 1'b1;
      end
    end
  end

  assign last_beat = (beat_cnt == len_q);
  assign w_hs      = (state == DATA) && bus.req_wvalid[g] && bus.m_wready;
  assign b_hs      = (state == RESP) && bus.m_bvalid && bus.req_bready[g];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      g                <= '0;
      last_grant       <= GW'(N_REQ - 1);
      beat_cnt         <= '0;
      len_q            <= '0;
      bus.grant        <= '0;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.protocol_err <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_vld) begin
            g         <= sel;
            bus.grant <= N_REQ'(1) << sel;
            state     <= ADDR;
          end
        end
        ADDR: begin
          // A withdrawn request gives up its turn without moving the pointer
          if (!bus.req_awvalid[g]) begin
            bus.grant <= '0;
            state     <= IDLE;
          end else if (bus.m_awready) begin
            len_q    <= awlen_a[g];
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (bus.req_wlast[g] != last_beat) bus.protocol_err <= 1'b1;
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            last_grant <= g;
            bus.grant  <= '0;
            state      <= IDLE;
            if (bus.m_bid != BUS_WIDTH'(AWID)) bus.protocol_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel muxes depend only on state and owner, never on m_*ready
  always_comb begin
    bus.m_awid      = BUS_WIDTH'(AWID);
    bus.m_awaddr    = awaddr_a[g];
    bus.m_awlen     = awlen_a[g];
    bus.m_awsize    = awsize_a[g];
    bus.m_awburst   = 2'b01;
    bus.m_awvalid   = (state == ADDR) && bus.req_awvalid[g];
    bus.m_wid       = BUS_WIDTH'(AWID);
    bus.m_wdata     = wdata_a[g];
    bus.m_wstrb     = wstrb_a[g];
    bus.m_wlast     = (state == DATA) && last_beat;
    bus.m_wvalid    = (state == DATA) && bus.req_wvalid[g];
    bus.m_bready    = (state == RESP) && bus.req_bready[g];
    bus.req_bresp   = bus.m_bresp;
    bus.req_awready = '0;
    bus.req_wready  = '0;
    bus.req_bvalid  = '0;
    bus.req_awready[g] = (state == ADDR) && bus.m_awready;
    bus.req_wready[g]  = (state == DATA) && bus.m_wready;
    bus.req_bvalid[g]  = (state == RESP) && bus.m_bvalid;
  end
endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// Bench for axi3_wr_arbiter: vector table of single transactions, round-robin
// and reset sequences, with AW/W scoreboards checked by a negedge monitor.
module tb_axi3_wr_arbiter;
  localparam int unsigned N_REQ = 2;
  localparam int unsigned AWID  = 2;
  localparam int unsigned BW    = 4;

  typedef struct { logic [31:0] addr; logic [3:0] len; logic [2:0] size; } aw_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic exp_last; logic drv_last; } w_t;
  typedef struct {
    int r; logic [31:0] addr; logic [3:0] len; logic [2:0] size;
    int aw_delay; bit w_toggle; int b_delay; logic [3:0] bid; logic [1:0] bresp; int err_beat;
    logic [1:0] exp_grant; int exp_beats; int exp_errs;
  } vec_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  axi3_wr_arbiter_if #(.N_REQ(N_REQ), .BUS_WIDTH(BW)) bus ();
  axi3_wr_arbiter #(.N_REQ(N_REQ), .AWID(AWID), .BUS_WIDTH(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  aw_t aw_q [N_REQ][$];
  w_t  w_q  [N_REQ][$];
  logic [1:0] rr_log [$];
  int beats_seen, b_seen, err_pulses;

  int cfg_aw_delay, cfg_b_delay;
  bit cfg_w_toggle;
  logic [3:0] cfg_bid;
  logic [1:0] cfg_bresp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred/expired, required otherwise at %0t", name, $time);
  endtask

  task automatic set_cfg(input int aw_d, input bit tog, input int b_d, input logic [3:0] bid, input logic [1:0] bresp);
    cfg_aw_delay = aw_d; cfg_w_toggle = tog; cfg_b_delay = b_d; cfg_bid = bid; cfg_bresp = bresp;
  endtask

  // Interconnect responder: delayed AWREADY, optional toggling WREADY, delayed BVALID
  int aw_wait, b_wait;
  initial begin
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0;
    bus.m_bid = '0; bus.m_bresp = '0; aw_wait = 0; b_wait = 0;
    forever begin
      @(posedge clk); #2;
      if (!bus.m_awvalid) begin aw_wait = 0; bus.m_awready = 1'b0; end
      else if (aw_wait >= cfg_aw_delay) bus.m_awready = 1'b1;
      else begin bus.m_awready = 1'b0; aw_wait++; end
      bus.m_wready = cfg_w_toggle ? ~bus.m_wready : 1'b1;
      if (!bus.m_bready) begin b_wait = 0; bus.m_bvalid = 1'b0; end
      else if (b_wait >= cfg_b_delay) bus.m_bvalid = 1'b1;
      else b_wait++;
      bus.m_bid = cfg_bid;
      bus.m_bresp = cfg_bresp;
    end
  end

  // Monitor: handshakes pop the scoreboards; protocol_err predicted one cycle ahead
  logic err_exp, mon_nxt;
  int mon_owner;
  aw_t mon_aw;
  w_t mon_w;
  initial begin
    err_exp = 1'b0; beats_seen = 0; b_seen = 0; err_pulses = 0;
    forever begin
      @(negedge clk);
      check("protocol_err", 32'(bus.protocol_err), 32'(err_exp));
      if (bus.protocol_err) err_pulses++;
      check("non_owner_outputs", 32'((bus.req_awready | bus.req_wready | bus.req_bvalid) & ~bus.grant), 32'd0);
      mon_owner = (bus.grant == 2'b01) ? 0 : (bus.grant == 2'b10) ? 1 : -1;
      mon_nxt = 1'b0;
      if (rst) begin
        if (bus.m_awvalid && bus.m_awready) begin
          rr_log.push_back(bus.grant);
          if (mon_owner < 0 || aw_q[mon_owner].size() == 0) fail_event("aw_unexpected");
          else begin
            mon_aw = aw_q[mon_owner].pop_front();
            check("m_awaddr", bus.m_awaddr, mon_aw.addr);
            check("m_awlen", 32'(bus.m_awlen), 32'(mon_aw.len));
            check("m_awsize", 32'(bus.m_awsize), 32'(mon_aw.size));
            check("m_awburst", 32'(bus.m_awburst), 32'd1);
            check("m_awid", 32'(bus.m_awid), AWID);
          end
        end
        if (bus.m_wvalid && bus.m_wready) begin
          beats_seen++;
          if (mon_owner < 0 || w_q[mon_owner].size() == 0) fail_event("w_extra_beat");
          else begin
            mon_w = w_q[mon_owner].pop_front();
            check("m_wdata", bus.m_wdata, mon_w.data);
            check("m_wstrb", 32'(bus.m_wstrb), 32'(mon_w.strb));
            check("m_wlast", 32'(bus.m_wlast), 32'(mon_w.exp_last));
            check("m_wid", 32'(bus.m_wid), AWID);
            mon_nxt = mon_nxt | (mon_w.drv_last != mon_w.exp_last);
          end
        end
        if (bus.m_bvalid && bus.m_bready) begin
          b_seen++;
          check("req_bvalid_route", 32'(bus.req_bvalid), 32'(bus.req_bready));
          check("req_bresp", 32'(bus.req_bresp), 32'(cfg_bresp));
          mon_nxt = mon_nxt | (32'(cfg_bid) != AWID);
        end
      end
      err_exp = mon_nxt;
    end
  end

  task automatic aw_phase(input int r, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
    aw_t a;
    bit ok;
    a.addr = addr; a.len = len; a.size = size;
    aw_q[r].push_back(a);
    bus.req_awaddr[r*32 +: 32] = addr;
    bus.req_awlen[r*4 +: 4] = len;
    bus.req_awsize[r*3 +: 3] = size;
    bus.req_awvalid[r] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.req_awready[r]) begin ok = 1'b1; break; end
    end
    if (ok) check("grant_at_aw", 32'(bus.grant), 32'(1) << r);
    else fail_event("aw_timeout");
    @(posedge clk); #1;
    bus.req_awvalid[r] = 1'b0;
  endtask

  task automatic drive_beat(input int r, input logic [31:0] data, input logic [3:0] strb, input logic exp_last, input logic drv_last);
    w_t w;
    bit ok;
    w.data = data; w.strb = strb; w.exp_last = exp_last; w.drv_last = drv_last;
    w_q[r].push_back(w);
    bus.req_wdata[r*32 +: 32] = data;
    bus.req_wstrb[r*4 +: 4] = strb;
    bus.req_wlast[r] = drv_last;
    bus.req_wvalid[r] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.req_wready[r]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_event("w_timeout");
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input int r, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input int err_beat, input logic [31:0] dbase);
    bit ok;
    aw_phase(r, addr, len, size);
    for (int b = 0; b <= int'(len); b++)
      drive_beat(r, dbase + 32'(b), ~4'(b), (b == int'(len)), (b == int'(len)) || (b == err_beat));
    bus.req_wvalid[r] = 1'b0;
    bus.req_wlast[r] = 1'b0;
    bus.req_bready[r] = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.req_bvalid[r]) begin ok = 1'b1; break; end
    end
    if (!ok) fail_event("b_timeout");
    @(posedge clk); #1;
    bus.req_bready[r] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_protocol_err"}, 32'(bus.protocol_err), 32'd0);
    check({tag, "_m_awvalid"}, 32'(bus.m_awvalid), 32'd0);
    check({tag, "_m_wvalid"}, 32'(bus.m_wvalid), 32'd0);
    check({tag, "_m_bready"}, 32'(bus.m_bready), 32'd0);
    check({tag, "_req_awready"}, 32'(bus.req_awready), 32'd0);
    check({tag, "_req_wready"}, 32'(bus.req_wready), 32'd0);
    check({tag, "_req_bvalid"}, 32'(bus.req_bvalid), 32'd0);
  endtask

  vec_t vecs [6];
  int b0, bs0, e0;

  initial begin
    vecs[0] = '{0, 32'h1000_0000, 4'd7,  3'd2, 0, 1'b0, 0, 4'd2, 2'b00, -1, 2'b01, 8,  0};
    vecs[1] = '{1, 32'h2000_0040, 4'd3,  3'd2, 3, 1'b1, 5, 4'd2, 2'b10, -1, 2'b10, 4,  0};
    vecs[2] = '{1, 32'h2000_0080, 4'd3,  3'd2, 0, 1'b0, 0, 4'd2, 2'b00,  1, 2'b10, 4,  1};
    vecs[3] = '{1, 32'h3000_0000, 4'd1,  3'd1, 1, 1'b0, 2, 4'd2, 2'b11, -1, 2'b10, 2,  0};
    vecs[4] = '{0, 32'h4000_0100, 4'd15, 3'd2, 0, 1'b1, 1, 4'd2, 2'b01, -1, 2'b01, 16, 0};
    vecs[5] = '{0, 32'h5000_0000, 4'd0,  3'd0, 2, 1'b0, 0, 4'd0, 2'b00, -1, 2'b01, 1,  1};

    rst = 1'b0;
    bus.req_awaddr = '0; bus.req_awlen = '0; bus.req_awsize = '0; bus.req_awvalid = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.req_wlast = '0; bus.req_wvalid = '0; bus.req_bready = '0;
    set_cfg(0, 1'b0, 0, 4'd2, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

    // Two requesters holding AWVALID must alternate
    rr_log.delete();
    fork
      begin run_txn(0, 32'h0000_1000, 4'd1, 3'd2, -1, 32'hA000); run_txn(0, 32'h0000_2000, 4'd1, 3'd2, -1, 32'hA100); end
      begin run_txn(1, 32'h0000_3000, 4'd2, 3'd2, -1, 32'hB000); run_txn(1, 32'h0000_4000, 4'd0, 3'd2, -1, 32'hB100); end
    join
    check("rr_count", 32'(rr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("rr_grant_seq", (rr_log.size() > i) ? 32'(rr_log[i]) : 32'd0, (i % 2 == 0) ? 32'd1 : 32'd2);

    for (int k = 0; k < 6; k++) begin
      set_cfg(vecs[k].aw_delay, vecs[k].w_toggle, vecs[k].b_delay, vecs[k].bid, vecs[k].bresp);
      b0 = beats_seen; bs0 = b_seen; e0 = err_pulses;
      rr_log.delete();
      run_txn(vecs[k].r, vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].err_beat, 32'(k) << 16);
      repeat (2) @(negedge clk);
      check("vec_grant", (rr_log.size() > 0) ? 32'(rr_log[0]) : 32'd0, 32'(vecs[k].exp_grant));
      check("vec_beats", 32'(beats_seen - b0), 32'(vecs[k].exp_beats));
      check("vec_b_count", 32'(b_seen - bs0), 32'd1);
      check("vec_err_pulses", 32'(err_pulses - e0), 32'(vecs[k].exp_errs));
      check("vec_idle_grant", 32'(bus.grant), 32'd0);
      check("vec_w_left", 32'(w_q[vecs[k].r].size()), 32'd0);
      @(posedge clk); #1;
    end

    // Reset after two beats: abandon the burst, pointer back to requester 0
    set_cfg(0, 1'b0, 0, 4'd2, 2'b00);
    aw_phase(0, 32'h6000_0000, 4'd7, 3'd2);
    drive_beat(0, 32'h0006_0000, 4'hF, 1'b0, 1'b0);
    drive_beat(0, 32'h0006_0001, 4'hF, 1'b0, 1'b0);
    bus.req_wvalid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    check("rst_mid_w_left", 32'(w_q[0].size()), 32'd0);
    @(posedge clk); #1;
    b0 = beats_seen;
    rr_log.delete();
    fork
      run_txn(1, 32'h7000_0000, 4'd1, 3'd2, -1, 32'h7100);
      run_txn(0, 32'h7000_1000, 4'd1, 3'd2, -1, 32'h7000);
    join
    check("post_rst_first_grant", (rr_log.size() > 0) ? 32'(rr_log[0]) : 32'd0, 32'd1);
    check("post_rst_second_grant", (rr_log.size() > 1) ? 32'(rr_log[1]) : 32'd0, 32'd2);
    check("post_rst_beats", 32'(beats_seen - b0), 32'd4);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi3_wr_arbiter.md
Name: axi3_wr_arbiter

Overview:
- Shares one AXI3 write master port among N_REQ write-side requesters, e.g. the dcache write_buffer and the uncached store path.
- Grants one requester at a time in round-robin order.
- Holds the grant from the AW handshake through the B handshake, so at most one transaction is outstanding.
- Generates WLAST from its own beat counter and flags requester protocol errors.
- Sits between the cache-side write engines and the axi3_wr_if toward the interconnect.

Parameters:
N_REQ, 2, number of requesters (2..4).
AWID, 2, constant ID driven on m_awid/m_wid and expected on m_bid.
BUS_WIDTH, 4, width of the ID field.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_awaddr  in  N_REQ*32  per-requester burst address
req_awlen  in  N_REQ*4  per-requester beats-1
req_awsize  in  N_REQ*3  per-requester beat size
req_awvalid  in  N_REQ  address valid
req_awready  out  N_REQ  address accepted
req_wdata  in  N_REQ*32  write data
req_wstrb  in  N_REQ*4  byte strobes
req_wlast  in  N_REQ  requester's last-beat marker (checked only)
req_wvalid  in  N_REQ  data valid
req_wready  out  N_REQ  data accepted
req_bvalid  out  N_REQ  response valid
req_bready  in  N_REQ  response accepted
req_bresp  out  2  response code, broadcast
m_awid/m_awaddr/m_awlen/m_awsize/m_awburst  out  BUS_WIDTH/32/4/3/2  AW channel
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wid/m_wdata/m_wstrb/m_wlast  out  BUS_WIDTH/32/4/1  W channel
m_wvalid  out  1  W valid
m_wready  in  1  W ready
m_bid  in  BUS_WIDTH  response ID
m_bresp  in  2  response code
m_bvalid  in  1  response valid
m_bready  out  1  response accepted
grant  out  N_REQ  one-hot owner, 0 in IDLE
protocol_err  out  1  one-cycle pulse

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, last_grant=N_REQ-1 (requester 0 wins first), beat_cnt=0, len_q=0.
  - All valid, ready, grant and protocol_err outputs are 0.
  - Reset mid-transaction abandons it silently; no B is forwarded afterwards.
- Constant fields: m_awburst=2'b01 (INCR); m_awid=m_wid=AWID.
- IDLE:
  - If any req_awvalid is set, select the first set bit searching from last_grant+1 with wrap-around.
  - Register the owner g and move to ADDR the next cycle; the selection costs one cycle of latency.
  - With no requests, stay in IDLE.
- ADDR:
  - m_aw* is muxed combinationally from requester g; m_awvalid=req_awvalid[g]; req_awready[g]=m_awready.
  - On the handshake, latch len_q=awlen, clear beat_cnt and move to DATA.
  - If req_awvalid[g] drops before the handshake, return to IDLE without updating last_grant.
- DATA:
  - m_w* is muxed from g; m_wvalid=req_wvalid[g]; req_wready[g]=m_wready.
  - m_wlast=(beat_cnt==len_q), regardless of req_wlast.
  - On each beat beat_cnt increments. On the last beat move to RESP.
  - protocol_err pulses if req_wlast[g] differs from m_wlast on any accepted beat.
- RESP:
  - req_bvalid[g]=m_bvalid; m_bready=req_bready[g]; req_bresp=m_bresp.
  - On the handshake: last_grant<=g, move to IDLE, and protocol_err pulses if m_bid!=AWID.
- Outputs not to the owner: req_*ready and req_bvalid are 0 for every non-owner in all states.
- Concurrent requests: new requests during a transaction wait; a requester holding awvalid is never starved. Worst case is N_REQ-1 transactions ahead of it.
- Back-to-back: the minimum cycle for one transaction is IDLE→ADDR→DATA×(len+1)→RESP→IDLE. There is no bypass of IDLE.
- All output muxes are pure combinational functions of state and g; there is no combinational path from m_*ready to m_*valid.

Test Plan:
- Single requester:
  - req0 sends awaddr=0x1000_0000, awlen=7, 8 beats 0x0..0x7, m_*ready=1.
  - Required: exactly 8 W beats with m_wlast only on beat 8, then one B routed to req0.
  - Required: grant=01 throughout, then 00.
- Round-robin: req0 and req1 both hold awvalid continuously for 4 transactions → grant sequence 01,10,01,10.
- Backpressure:
  - m_awready delayed 3 cycles, m_wready toggling 1/0, m_bvalid delayed 5 cycles.
  - Required: data order preserved, no dropped or duplicated beats, len=3 gives 4 beats.
- Protocol error:
  - req1 asserts wlast on beat 2 of a len=3 burst → protocol_err pulses once on that beat, transfer still completes with 4 beats.
  - m_bid=0 with AWID=2 → protocol_err pulses on the B handshake.
- Reset mid-DATA:
  - rst low for 1 cycle after beat 2.
  - Required: all outputs 0 the next cycle, state IDLE, req0 wins the next arbitration.
